// File: rtl/mcu_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// mcu_tx_scheduler_if
// Bundles the request side (command sources) and the serializer side of the
// MCU transmit scheduler into one interface.
//   req_valid   per-source one-cycle request strobe
//   req_byte    per-source byte, slice i = [8i+7:8i]
//   req_done    per-source completion pulse
//   req_err     per-source timeout pulse
//   req_ovf     per-source sticky overflow flag
//   ovf_clr     clears every req_ovf bit
//   byte_out    byte handed to the serializer
//   byte_out_en one-cycle serializer load strobe
//   tx_end      serializer end-of-byte pulse
//   busy        scheduler is not idle
// master: the environment (sources + serializer); slave: the scheduler.
// ---------------------------------------------------------------------------
interface mcu_tx_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_byte;
    logic [NREQ-1:0]   req_done;
    logic [NREQ-1:0]   req_err;
    logic [NREQ-1:0]   req_ovf;
    logic              ovf_clr;
    logic [7:0]        byte_out;
    logic              byte_out_en;
    logic              tx_end;
    logic              busy;

    modport master (
        output req_valid, req_byte, ovf_clr, tx_end,
        input  req_done, req_err, req_ovf, byte_out, byte_out_en, busy
    );

    modport slave (
        input  req_valid, req_byte, ovf_clr, tx_end,
        output req_done, req_err, req_ovf, byte_out, byte_out_en, busy
    );
endinterface

// File: rtl/mcu_tx_scheduler.sv
// ---------------------------------------------------------------------------
// mcu_tx_scheduler
// Shares one UART byte serializer between NREQ command sources. Each source
// owns a one-byte slot; a round-robin arbiter picks the next pending slot,
// the byte is loaded into the serializer, tx_end (or a timeout) completes it,
// and an inter-byte gap is enforced before the next launch.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mcu_tx_scheduler_if.slave (request, status and serializer signals)
// ---------------------------------------------------------------------------
module mcu_tx_scheduler #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 200,
    parameter int TIMEOUT    = 20000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mcu_tx_scheduler_if.slave      bus
);
    localparam int          IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] GAP_C     = 16'(GAP_CYCLES);
    localparam logic [15:0] TO_LAST_C = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   grant_r;
    logic [15:0]     cnt_r;
    logic [NREQ-1:0] pend_r;
    logic [7:0]      slot_r [NREQ];
    logic [7:0]      byte_out_r;
    logic            byte_out_en_r;
    logic            busy_r;
    logic [NREQ-1:0] req_done_r;
    logic [NREQ-1:0] req_err_r;
    logic [NREQ-1:0] req_ovf_r;

    logic [IW-1:0]   pick_s;
    logic            to_hit_s;
    logic [NREQ-1:0] release_s;

    // First pending slot at or after ptr, wrapping; scanning backwards lets
    // the closest candidate overwrite the farther ones.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] pend,
                                              input logic [IW-1:0]   ptr);
        logic [IW-1:0] sel;
        logic [IW-1:0] idx;
        sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (pend[idx]) begin
                sel = idx;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Arbiter pick and timeout detection.
    // The counter is cleared in LOAD, so the timeout fires TIMEOUT clocks
    // after the byte_out_en cycle.
    always_comb begin
        pick_s   = rr_pick(pend_r, ptr_r);
        to_hit_s = ((cnt_r + 16'd1) >= TO_LAST_C);
    end

    // Slot release vector: the granted slot frees up on done or timeout.
    always_comb begin
        release_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_r == ST_WAIT) && (grant_r == IW'(i)) && (bus.tx_end || to_hit_s)) begin
                release_s[i] = 1'b1;
            end else begin
                release_s[i] = 1'b0;
            end
        end
    end

    // Per-source slots, pending flags and sticky overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r    <= '0;
            req_ovf_r <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && (!pend_r[i] || release_s[i])) begin
                    slot_r[i] <= bus.req_byte[8*i +: 8];
                    pend_r[i] <= 1'b1;
                end else if (release_s[i]) begin
                    pend_r[i] <= 1'b0;
                end else begin
                    pend_r[i] <= pend_r[i];
                end
            end
            // Clear wins over a same-cycle overflow.
            if (bus.ovf_clr) begin
                req_ovf_r <= '0;
            end else begin
                req_ovf_r <= req_ovf_r | (bus.req_valid & pend_r & ~release_s);
            end
        end
    end

    // Launch FSM with registered serializer strobe and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            grant_r       <= '0;
            cnt_r         <= 16'd0;
            byte_out_r    <= 8'h00;
            byte_out_en_r <= 1'b0;
            busy_r        <= 1'b0;
            req_done_r    <= '0;
            req_err_r     <= '0;
        end else begin
            req_done_r <= '0;
            req_err_r  <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (|pend_r) begin
                        grant_r       <= pick_s;
                        byte_out_r    <= slot_r[pick_s];
                        byte_out_en_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ST_LOAD;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    byte_out_en_r <= 1'b0;
                    cnt_r         <= 16'd0;
                    state_r       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // tx_end beats a coincident timeout.
                    if (bus.tx_end || to_hit_s) begin
                        if (bus.tx_end) begin
                            req_done_r[grant_r] <= 1'b1;
                        end else begin
                            req_err_r[grant_r] <= 1'b1;
                        end
                        ptr_r   <= (grant_r == IW'(NREQ - 1)) ? '0 : grant_r + IW'(1);
                        cnt_r   <= 16'd0;
                        state_r <= ST_GAP;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_C) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    byte_out_en_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.byte_out    = byte_out_r;
    assign bus.byte_out_en = byte_out_en_r;
    assign bus.busy        = busy_r;
    assign bus.req_done    = req_done_r;
    assign bus.req_err     = req_err_r;
    assign bus.req_ovf     = req_ovf_r;

endmodule

// File: tb/tb_mcu_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mcu_tx_scheduler
// Directed bench for mcu_tx_scheduler (NREQ=4, GAP_CYCLES=4, TIMEOUT=50).
// Inputs change 1 ns after a rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_mcu_tx_scheduler;
    localparam int NREQ = 4;
    localparam int GAP  = 4;
    localparam int TO   = 50;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   en_cyc;
    int   tx_cyc;
    int   err_cyc;
    int   lcyc;
    logic [7:0] got;

    mcu_tx_scheduler_if #(.NREQ(NREQ)) bus ();

    mcu_tx_scheduler #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure latencies.
    always @(posedge clk) cyc <= cyc + 1;

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int src, input logic [7:0] b);
        bus.req_valid      = 4'b0000;
        bus.req_valid[src] = 1'b1;
        bus.req_byte[8*src +: 8] = b;
        tick();
        bus.req_valid = 4'b0000;
    endtask

    // Wait (bounded) for the load strobe and return the launched byte.
    task automatic wait_en(output logic [7:0] b);
        int n;
        n = 0;
        while (bus.byte_out_en !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("en_seen", {31'd0, bus.byte_out_en}, 32'd1);
        b      = bus.byte_out;
        en_cyc = cyc;
    endtask

    // Two cycles into WAIT_END, pulse tx_end for one cycle.
    task automatic finish_byte();
        tick();
        tick();
        tx_cyc     = cyc;
        bus.tx_end = 1'b1;
        tick();
        bus.tx_end = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_byte  = 32'h0000_0000;
        bus.ovf_clr   = 1'b0;
        bus.tx_end    = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_en", {31'd0, bus.byte_out_en}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_byte", {24'd0, bus.byte_out}, 32'h00);
        check("rst_done", {28'd0, bus.req_done}, 32'd0);
        check("rst_err", {28'd0, bus.req_err}, 32'd0);
        check("rst_ovf", {28'd0, bus.req_ovf}, 32'd0);

        // ---- single request: byte 0xAC from source 0 ----
        post(0, 8'hAC);                        // after edge 0
        check("s_en_e0", {31'd0, bus.byte_out_en}, 32'd0);
        check("s_busy_e0", {31'd0, bus.busy}, 32'd0);
        tick();                                // after edge 1: LOAD
        check("s_en_e1", {31'd0, bus.byte_out_en}, 32'd1);
        check("s_byte", {24'd0, bus.byte_out}, 32'hAC);
        check("s_busy_e1", {31'd0, bus.busy}, 32'd1);
        tick();
        check("s_en_one", {31'd0, bus.byte_out_en}, 32'd0);
        check("s_byte_hold", {24'd0, bus.byte_out}, 32'hAC);
        for (int i = 0; i < 9; i++) tick();
        bus.tx_end = 1'b1;                     // tx_end cycle c
        tick();
        bus.tx_end = 1'b0;
        check("s_done", {28'd0, bus.req_done}, 32'b0001);
        check("s_err", {28'd0, bus.req_err}, 32'd0);
        tick();
        check("s_done_pulse", {28'd0, bus.req_done}, 32'd0);
        tick();
        tick();
        tick();                                // c+5: still in the gap
        check("s_busy_gap", {31'd0, bus.busy}, 32'd1);
        tick();                                // c+6
        check("s_busy_low", {31'd0, bus.busy}, 32'd0);

        // ---- round-robin from ptr=0 ----
        do_reset();
        bus.req_valid = 4'b1011;
        bus.req_byte  = {8'hAA, 8'h00, 8'h55, 8'h59};
        tick();
        bus.req_valid = 4'b0000;
        wait_en(got);
        check("rr_first", {24'd0, got}, 32'h59);
        finish_byte();
        check("rr_done0", {28'd0, bus.req_done}, 32'b0001);
        wait_en(got);
        check("rr_second", {24'd0, got}, 32'h55);
        check("rr_gap1", {31'd0, (en_cyc - tx_cyc) >= GAP + 2}, 32'd1);
        finish_byte();
        check("rr_done1", {28'd0, bus.req_done}, 32'b0010);
        wait_en(got);
        check("rr_third", {24'd0, got}, 32'hAA);
        check("rr_gap2", {31'd0, (en_cyc - tx_cyc) >= GAP + 2}, 32'd1);
        finish_byte();
        check("rr_done3", {28'd0, bus.req_done}, 32'b1000);

        // ---- overflow on source 2 ----
        post(2, 8'hA6);
        post(2, 8'h11);
        check("ovf_set", {28'd0, bus.req_ovf}, 32'b0100);
        wait_en(got);
        check("ovf_keep_old", {24'd0, got}, 32'hA6);
        finish_byte();
        check("ovf_done", {28'd0, bus.req_done}, 32'b0100);
        check("ovf_sticky", {28'd0, bus.req_ovf}, 32'b0100);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", {28'd0, bus.req_ovf}, 32'd0);
        post(1, 8'h33);
        bus.ovf_clr = 1'b1;                    // clear against a new overflow
        post(1, 8'h44);
        bus.ovf_clr = 1'b0;
        check("ovf_clr_prio", {28'd0, bus.req_ovf}, 32'd0);
        wait_en(got);
        check("ovf_src1_old", {24'd0, got}, 32'h33);
        finish_byte();
        check("ovf_done1", {28'd0, bus.req_done}, 32'b0010);

        // ---- same-cycle reload of source 0 ----
        post(0, 8'h10);
        wait_en(got);
        check("rl_first", {24'd0, got}, 32'h10);
        tick();
        tick();
        tx_cyc        = cyc;
        bus.tx_end    = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_byte[7:0] = 8'h22;
        tick();
        bus.tx_end    = 1'b0;
        bus.req_valid = 4'b0000;
        check("rl_done", {28'd0, bus.req_done}, 32'b0001);
        check("rl_no_ovf", {28'd0, bus.req_ovf}, 32'd0);
        wait_en(got);
        check("rl_second", {24'd0, got}, 32'h22);
        check("rl_gap", {31'd0, (en_cyc - tx_cyc) >= GAP + 2}, 32'd1);
        finish_byte();
        check("rl_done2", {28'd0, bus.req_done}, 32'b0001);

        // ---- timeout on source 1, then source 2 ----
        bus.req_valid = 4'b0110;
        bus.req_byte  = {8'h00, 8'hA5, 8'h5A, 8'h00};
        tick();
        bus.req_valid = 4'b0000;
        wait_en(got);
        check("to_byte", {24'd0, got}, 32'h5A);
        lcyc = en_cyc;
        for (int n = 0; n < 100 && bus.req_err === 4'b0000; n++) tick();
        err_cyc = cyc;
        check("to_err", {28'd0, bus.req_err}, 32'b0010);
        check("to_latency", err_cyc - lcyc, TO);
        check("to_no_done", {28'd0, bus.req_done}, 32'd0);
        bus.tx_end = 1'b1;                     // late tx_end lands in the gap
        tick();
        bus.tx_end = 1'b0;
        check("to_late_ignored", {28'd0, bus.req_done}, 32'd0);
        wait_en(got);
        check("to_next", {24'd0, got}, 32'hA5);
        check("to_gap", {31'd0, (en_cyc - err_cyc) >= GAP + 1}, 32'd1);
        finish_byte();
        check("to_done2", {28'd0, bus.req_done}, 32'b0100);

        // ---- reset in the middle of WAIT_END ----
        post(3, 8'h77);
        wait_en(got);
        check("mr_byte", {24'd0, got}, 32'h77);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mr_busy", {31'd0, bus.busy}, 32'd0);
        check("mr_byte0", {24'd0, bus.byte_out}, 32'h00);
        check("mr_en", {31'd0, bus.byte_out_en}, 32'd0);
        bus.tx_end = 1'b1;
        tick();
        tick();
        rst_n      = 1'b1;
        bus.tx_end = 1'b0;
        tick();
        check("mr_no_done", {28'd0, bus.req_done}, 32'd0);
        check("mr_no_err", {28'd0, bus.req_err}, 32'd0);
        bus.req_valid = 4'b1110;
        bus.req_byte  = {8'h01, 8'h02, 8'h03, 8'h00};
        tick();
        bus.req_valid = 4'b0000;
        wait_en(got);
        check("mr_lowest", {24'd0, got}, 32'h03);
        finish_byte();
        check("mr_done", {28'd0, bus.req_done}, 32'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
